// File: rtl/sram1p_req_ctrl.sv
// sram1p_req_ctrl: request/response front-end for the single-port SRAM macro (sram1p).
//
// A valid/ready request stream of reads and writes becomes the macro's active-low ce_n/we_n
// strobes. Read data arrives one cycle after the read strobe. It is captured into a hold
// register and returned on a valid/ready response channel. Writes produce no response. An
// out-of-range address never strobes the macro. An out-of-range read still produces a response,
// with rdata=0 and err=1. Every output is registered.
//
// Optional feature: define SRAM1P_REQ_CTRL_INIT_CLEAR_EN to zero-fill the SRAM after reset,
// one word per cycle, before the first request is accepted.
//
// Ports
//   clk_i          clock, rising edge; also clocks the attached SRAM
//   rst_i          synchronous, active-high reset
//   req_valid_i    request present
//   req_ready_o    request can be accepted this cycle
//   req_we_i       1 = write, 0 = read
//   req_addr_i     word address
//   req_wdata_i    write data (ignored for reads)
//   rsp_valid_o    read response present
//   rsp_ready_i    response consumer ready
//   rsp_rdata_o    read data
//   rsp_err_o      response is for an out-of-range address
//   sram_addr_o    to sram1p addr
//   sram_we_n_o    to sram1p we_n
//   sram_ce_n_o    to sram1p ce_n
//   sram_din_o     to sram1p din
//   sram_dout_i    from sram1p dout (valid one cycle after a read strobe, zero otherwise)
module sram1p_req_ctrl #(
  parameter int unsigned SRAM_SIZE  = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic                  sram_we_n_o,
  output logic                  sram_ce_n_o,
  output logic [DATA_WIDTH-1:0] sram_din_o,
  input  logic [DATA_WIDTH-1:0] sram_dout_i
);

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdCapture,
    StRspHold,
    StInit
  } state_e;

  // One extra bit so that SRAM_SIZE == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] SramSizeW = (ADDR_WIDTH + 1)'(SRAM_SIZE);

`ifdef SRAM1P_REQ_CTRL_INIT_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(SRAM_SIZE - 1);
  localparam state_e                StReset   = StInit;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
`else
  localparam state_e                StReset   = StIdle;
`endif

  state_e                state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rd_err_q;   // error flag of the read in flight
  logic [ADDR_WIDTH-1:0] sram_addr_q;
  logic                  sram_we_n_q;
  logic                  sram_ce_n_q;
  logic [DATA_WIDTH-1:0] sram_din_q;

  logic req_fire;
  logic req_in_range;

  assign req_fire     = req_valid_i & req_ready_q;
  assign req_in_range = {1'b0, req_addr_i} < SramSizeW;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StReset;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rd_err_q    <= 1'b0;
      sram_addr_q <= '0;
      sram_we_n_q <= 1'b1;
      sram_ce_n_q <= 1'b1;
      sram_din_q  <= '0;
`ifdef SRAM1P_REQ_CTRL_INIT_CLEAR_EN
      init_cnt_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          sram_ce_n_q <= 1'b1;
          sram_we_n_q <= 1'b1;
          if (req_fire) begin
            if (req_we_i) begin
              // Out-of-range writes are dropped silently.
              if (req_in_range) begin
                sram_ce_n_q <= 1'b0;
                sram_we_n_q <= 1'b0;
                sram_addr_q <= req_addr_i;
                sram_din_q  <= req_wdata_i;
              end
            end else begin
              req_ready_q <= 1'b0;
              rd_err_q    <= ~req_in_range;
              state_q     <= StRdIssue;
              // Out-of-range reads walk the same states without touching the macro.
              if (req_in_range) begin
                sram_ce_n_q <= 1'b0;
                sram_addr_q <= req_addr_i;
              end
            end
          end
        end
        StRdIssue: begin
          sram_ce_n_q <= 1'b1;
          sram_we_n_q <= 1'b1;
          state_q     <= StRdCapture;
        end
        StRdCapture: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rd_err_q ? '0 : sram_dout_i;
          rsp_err_q   <= rd_err_q;
          state_q     <= StRspHold;
        end
        StRspHold: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
`ifdef SRAM1P_REQ_CTRL_INIT_CLEAR_EN
        StInit: begin
          sram_ce_n_q <= 1'b0;
          sram_we_n_q <= 1'b0;
          sram_addr_q <= init_cnt_q;
          sram_din_q  <= '0;
          if (init_cnt_q == LastAddr) begin
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            init_cnt_q  <= init_cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_q     <= StIdle;
          sram_ce_n_q <= 1'b1;
          sram_we_n_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign sram_addr_o = sram_addr_q;
  assign sram_we_n_o = sram_we_n_q;
  assign sram_ce_n_o = sram_ce_n_q;
  assign sram_din_o  = sram_din_q;

endmodule

// File: tb/tb_sram1p_req_ctrl.sv
// Self-checking bench for sram1p_req_ctrl. It contains a behavioural single-port SRAM: the
// write happens at the edge, and read data appears one cycle late and is zero when idle. A
// reference memory array predicts every read response.
module tb_sram1p_req_ctrl;
  localparam int unsigned SramSize = 2;
  localparam int unsigned Aw       = 8;
  localparam int unsigned Dw       = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [Aw-1:0] req_addr;
  logic [Dw-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [Dw-1:0] rsp_rdata;
  logic          rsp_err;
  logic [Aw-1:0] sram_addr;
  logic          sram_we_n;
  logic          sram_ce_n;
  logic [Dw-1:0] sram_din;
  logic [Dw-1:0] sram_dout = '0;

  int nvec  = 0;
  int nfail = 0;

  logic [Dw-1:0] sram_mem [256];
  logic [Dw-1:0] ref_mem  [256];
  int unsigned   wr_strobes = 0;
  int unsigned   rd_strobes = 0;

  always #5 clk = ~clk;

  sram1p_req_ctrl #(
    .SRAM_SIZE  (SramSize),
    .ADDR_WIDTH (Aw),
    .DATA_WIDTH (Dw)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .sram_addr_o (sram_addr),
    .sram_we_n_o (sram_we_n),
    .sram_ce_n_o (sram_ce_n),
    .sram_din_o  (sram_din),
    .sram_dout_i (sram_dout)
  );

  // Behavioural sram1p, plus strobe counters sampled at the edge the macro sees them.
  always @(posedge clk) begin
    if (!sram_ce_n) begin
      if (!sram_we_n) begin
        sram_mem[sram_addr] <= sram_din;
        sram_dout           <= '0;
        wr_strobes          <= wr_strobes + 1;
      end else begin
        sram_dout           <= sram_mem[sram_addr];
        rd_strobes          <= rd_strobes + 1;
      end
    end else begin
      sram_dout <= '0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Holds rst for `pre` edges, checks reset values, then releases and walks to idle.
  task automatic do_reset(input int pre);
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (pre) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_rsp_err",   64'(rsp_err),   64'(0));
    check("rst_ce_n",      64'(sram_ce_n), 64'(1));
    check("rst_we_n",      64'(sram_we_n), 64'(1));
    check("rst_addr",      64'(sram_addr), 64'(0));
    check("rst_din",       64'(sram_din),  64'(0));
    rst = 1'b0;
`ifdef SRAM1P_REQ_CTRL_INIT_CLEAR_EN
    for (int i = 0; i < SramSize; i++) begin
      @(negedge clk);
      check("init_ce_n",  64'(sram_ce_n), 64'(0));
      check("init_we_n",  64'(sram_we_n), 64'(0));
      check("init_addr",  64'(sram_addr), 64'(i));
      check("init_din",   64'(sram_din),  64'(0));
      check("init_ready", 64'(req_ready), 64'(i == SramSize - 1));
      ref_mem[i] = '0;
    end
`else
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'(1));
    check("post_rst_ce_n",  64'(sram_ce_n), 64'(1));
`endif
    check("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
  endtask

  // Starts and ends at a negedge with req_ready expected high.
  task automatic do_write(input logic [Aw-1:0] a, input logic [Dw-1:0] d, input bit last);
    check("wr_ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    if (a < Aw'(SramSize)) begin
      check("wr_ce_n", 64'(sram_ce_n), 64'(0));
      check("wr_we_n", 64'(sram_we_n), 64'(0));
      check("wr_addr", 64'(sram_addr), 64'(a));
      check("wr_din",  64'(sram_din),  64'(d));
      ref_mem[a] = d;
    end else begin
      check("wr_oor_ce_n", 64'(sram_ce_n), 64'(1));
    end
    check("wr_ready_after", 64'(req_ready), 64'(1));
    if (last) begin
      req_valid = 1'b0;
      req_we    = 1'b0;
    end
  endtask

  task automatic do_read(input logic [Aw-1:0] a, input int hold);
    logic          exp_e;
    logic [Dw-1:0] exp_d;
    int unsigned   wr0;
    int unsigned   rd0;
    exp_e = (a >= Aw'(SramSize));
    exp_d = exp_e ? '0 : ref_mem[a];
    check("rd_ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    req_wdata = $urandom;
    @(negedge clk);
    wr0       = wr_strobes;
    rd0       = rd_strobes;
    req_valid = 1'b0;
    req_addr  = Aw'($urandom);
    req_wdata = $urandom;
    check("issue_ready",     64'(req_ready), 64'(0));
    check("issue_rsp_valid", 64'(rsp_valid), 64'(0));
    check("issue_ce_n",      64'(sram_ce_n), 64'(exp_e));
    if (!exp_e) begin
      check("issue_we_n", 64'(sram_we_n), 64'(1));
      check("issue_addr", 64'(sram_addr), 64'(a));
    end
    @(negedge clk);
    check("cap_ce_n",      64'(sram_ce_n), 64'(1));
    check("cap_rsp_valid", 64'(rsp_valid), 64'(0));
    check("cap_ready",     64'(req_ready), 64'(0));
    @(negedge clk);
    check("rsp_valid", 64'(rsp_valid), 64'(1));
    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_d));
    check("rsp_err",   64'(rsp_err),   64'(exp_e));
    check("rsp_ready_low", 64'(req_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'(1));
      check("hold_rdata", 64'(rsp_rdata), 64'(exp_d));
      check("hold_err",   64'(rsp_err),   64'(exp_e));
      check("hold_ready", 64'(req_ready), 64'(0));
      check("hold_ce_n",  64'(sram_ce_n), 64'(1));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("done_rsp_valid", 64'(rsp_valid), 64'(0));
    check("done_ready",     64'(req_ready), 64'(1));
    check("done_rd_strobes", 64'(rd_strobes - rd0), 64'(!exp_e));
    check("done_wr_strobes", 64'(wr_strobes - wr0), 64'(0));
  endtask

  initial begin
    logic [Dw-1:0] d0;
    logic [Dw-1:0] d1;
    logic [Aw-1:0] ra;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    do_reset(2);
`ifdef SRAM1P_REQ_CTRL_INIT_CLEAR_EN
    do_read(Aw'(0), 0);
    do_read(Aw'(1), 0);
`endif

    // Write then read one word.
    do_write(Aw'(1), 32'hDEADBEEF, 1'b1);
    do_read(Aw'(1), 0);

    // Back-to-back writes, then read both.
    d0 = $urandom;
    d1 = $urandom;
    do_write(Aw'(0), d0, 1'b0);
    do_write(Aw'(1), d1, 1'b1);
    do_read(Aw'(0), 1);
    do_read(Aw'(1), 0);

    // Stalled response consumer.
    do_read(Aw'(0), 5);

    // Out-of-range read and write; in-range contents untouched.
    do_read(Aw'(2), 0);
    do_write(Aw'(5), $urandom, 1'b1);
    do_read(Aw'(0), 0);
    do_read(Aw'(1), 2);

    // Reset while the read is in its capture cycle: the response must never appear.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = Aw'(1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("aborted_no_rsp", 64'(rsp_valid), 64'(0));
    end
`ifndef SRAM1P_REQ_CTRL_INIT_CLEAR_EN
    // Contents after a plain reset are whatever was written; make them known again.
    do_write(Aw'(0), $urandom, 1'b1);
    do_write(Aw'(1), $urandom, 1'b1);
`endif

    // Randomised traffic, addresses 0..3 so half of them are out of range.
    for (int i = 0; i < 30; i++) begin
      ra = Aw'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        do_write(ra, $urandom, 1'b1);
      end else begin
        do_read(ra, int'($urandom_range(0, 3)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
